// File: rtl/quotient_bcd_receiver_if.sv
// quotient_bcd_receiver_if
//   Bundles the serial quotient input and the excess-3 digit output of
//   quotient_bcd_receiver.
//   in_valid  : serial quotient bit strobe
//   in_data   : quotient bit, MSB first
//   out_valid : digit nibble strobe
//   out_data  : excess-3 digit (digit + 3), most significant first
//   Modports: master = stimulus / upstream side, slave = receiver side.
interface quotient_bcd_receiver_if;
  logic       in_valid;
  logic       in_data;
  logic       out_valid;
  logic [3:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/quotient_bcd_receiver.sv
// quotient_bcd_receiver
//   Captures a 10-bit MSB-first serial quotient. A sequential double-dabble
//   engine converts it to four BCD digits, which are re-emitted as
//   excess-3 nibbles, thousands digit first.
//   Ports:
//     clk : rising-edge clock
//     rst : synchronous active-high reset (clears all state)
//     bus : quotient_bcd_receiver_if.slave
//           in_valid/in_data   serial quotient bits
//           out_valid/out_data excess-3 digit stream (registered)
//   Configuration macro:
//     ZERO_SUPPRESS_EN : when defined, leading zero digits are skipped. The
//                        units digit is always emitted.
module quotient_bcd_receiver (
  input logic                    clk,
  input logic                    rst,
  quotient_bcd_receiver_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, CONV, OUT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;   // bits captured in SHIFT, iterations in CONV
  logic [9:0]  bin_sr_q, bin_sr_d;
  logic [15:0] bcd_q, bcd_d;
  logic [1:0]  dig_cnt_q, dig_cnt_d;   // index of digit being presented, 3 = thousands
  logic        out_valid_q, out_valid_d;
  logic [3:0]  out_data_q, out_data_d;

  logic [25:0] dabble_w;

  // Add 3 to every BCD digit that is 5 or more, ahead of the left shift.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] b);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? (b[i*4 +: 4] + 4'd3) : b[i*4 +: 4];
    end
    return r;
  endfunction

  function automatic logic [3:0] digit_sel(input logic [15:0] b, input logic [1:0] idx);
    logic [3:0] d;
    case (idx)
      2'd3:    d = b[15:12];
      2'd2:    d = b[11:8];
      2'd1:    d = b[7:4];
      default: d = b[3:0];
    endcase
    return d;
  endfunction

  // Digits never exceed 9, so the 4-bit sum cannot wrap.
  function automatic logic [3:0] to_xs3(input logic [3:0] d);
    return d + 4'd3;
  endfunction

  // Index of the first digit to emit once conversion is done.
  function automatic logic [1:0] first_digit(input logic [15:0] b);
    logic [1:0] idx;
`ifdef ZERO_SUPPRESS_EN
    if (b[15:12] != 4'd0)      idx = 2'd3;
    else if (b[11:8] != 4'd0)  idx = 2'd2;
    else if (b[7:4] != 4'd0)   idx = 2'd1;
    else                       idx = 2'd0;
`else
    idx = (b == 16'hFFFF) ? 2'd3 : 2'd3;
`endif
    return idx;
  endfunction

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bin_sr_d  = bin_sr_q;
    bcd_d     = bcd_q;
    dig_cnt_d = dig_cnt_q;
    dabble_w  = {dabble_adjust(bcd_q), bin_sr_q};

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          bin_sr_d  = {bin_sr_q[8:0], bus.in_data};
          bit_cnt_d = 4'd1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.in_valid) begin
          bin_sr_d = {bin_sr_q[8:0], bus.in_data};
          if (bit_cnt_q == 4'd9) begin
            bcd_d     = 16'd0;
            bit_cnt_d = 4'd0;
            state_d   = CONV;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          // Short frame: drop it silently.
          state_d = IDLE;
        end
      end
      CONV: begin
        {bcd_d, bin_sr_d} = {dabble_w[24:0], 1'b0};
        if (bit_cnt_q == 4'd9) begin
          state_d   = OUT;
          dig_cnt_d = first_digit(bcd_d);
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      OUT: begin
        if (dig_cnt_q == 2'd0) state_d = IDLE;
        else                   dig_cnt_d = dig_cnt_q - 2'd1;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state values, so the first digit
    // appears in the first OUT cycle.
    out_valid_d = (state_d == OUT);
    out_data_d  = out_valid_d ? to_xs3(digit_sel(bcd_d, dig_cnt_d)) : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      bin_sr_q    <= 10'd0;
      bcd_q       <= 16'd0;
      dig_cnt_q   <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      bin_sr_q    <= bin_sr_d;
      bcd_q       <= bcd_d;
      dig_cnt_q   <= dig_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_quotient_bcd_receiver.sv
module tb_quotient_bcd_receiver;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  quotient_bcd_receiver_if bus();

  quotient_bcd_receiver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vld"}, {3'd0, bus.out_valid}, 4'd0);
    chk({tag, "_dat"}, bus.out_data, 4'd0);
  endtask

  // Drives 10 bits MSB first (10th bit presented in cycle k), then `extra`
  // further valid bits, then drops in_valid. Returns at negedge k+1+extra.
  task automatic send_frame(input logic [9:0] v, input int extra);
    for (int i = 9; i >= 0; i--) begin
      bus.in_valid = 1'b1;
      bus.in_data  = v[i];
      @(negedge clk);
    end
    for (int e = 0; e < extra; e++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 1'b0;
  endtask

  // Called at negedge k+since; checks idle at k+10, n digits from k+11,
  // idle at k+11+n, and returns at that negedge.
  task automatic expect_result(input string tag, input int since, input int n,
                               input logic [15:0] exp);
    repeat (10 - since) @(negedge clk);
    chk_idle({tag, "_pre"});
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_vld"}, {3'd0, bus.out_valid}, 4'd1);
      chk({tag, "_dig"}, bus.out_data, exp[15 - 4*i -: 4]);
    end
    @(negedge clk);
    chk_idle({tag, "_post"});
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset");

    // Last reset cycle carries a valid 1 bit that must be dropped; the
    // 123 frame then follows with in_valid never falling.
    bus.in_valid = 1'b1;
    bus.in_data  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_frame(10'd123, 0);
`ifdef ZERO_SUPPRESS_EN
    expect_result("f123", 1, 3, 16'h4560);
`else
    expect_result("f123", 1, 4, 16'h3456);
`endif

    // 0 then 1023 at the minimum gap.
    send_frame(10'd0, 0);
`ifdef ZERO_SUPPRESS_EN
    expect_result("f0", 1, 1, 16'h3000);
`else
    expect_result("f0", 1, 4, 16'h3333);
`endif
    send_frame(10'd1023, 0);
    expect_result("f1023", 1, 4, 16'h4356);

    send_frame(10'd999, 0);
`ifdef ZERO_SUPPRESS_EN
    expect_result("f999", 1, 3, 16'hCCC0);
`else
    expect_result("f999", 1, 4, 16'h3CCC);
`endif

    // Aborted frame after 6 bits.
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = i[0];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("abort_vld", {3'd0, bus.out_valid}, 4'd0);
    end
    send_frame(10'd500, 0);
`ifdef ZERO_SUPPRESS_EN
    expect_result("f500", 1, 3, 16'h8330);
`else
    expect_result("f500", 1, 4, 16'h3833);
`endif

    // Reset during the second OUT cycle of a 123 frame.
    send_frame(10'd123, 0);
    repeat (9) @(negedge clk);
    chk_idle("rst_pre");
    @(negedge clk);
    chk("rst_out1_vld", {3'd0, bus.out_valid}, 4'd1);
    @(negedge clk);
    chk("rst_out2_vld", {3'd0, bus.out_valid}, 4'd1);
`ifdef ZERO_SUPPRESS_EN
    chk("rst_out2_dig", bus.out_data, 4'h5);
`else
    chk("rst_out2_dig", bus.out_data, 4'h4);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("rst_after");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_quiet_vld", {3'd0, bus.out_valid}, 4'd0);
    end
    send_frame(10'd42, 0);
`ifdef ZERO_SUPPRESS_EN
    expect_result("f42", 1, 2, 16'h7500);
`else
    expect_result("f42", 1, 4, 16'h3375);
`endif

    // in_valid held for 14 cycles: the last 4 bits are ignored.
    send_frame(10'd123, 4);
`ifdef ZERO_SUPPRESS_EN
    expect_result("f123x", 5, 3, 16'h4560);
`else
    expect_result("f123x", 5, 4, 16'h3456);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
